// File: rtl/tt_dsp_sample_framer.sv
// Byte-pair sample framer: synchronizes an external byte strobe, pairs bytes into 16-bit
// samples and buffers them in a first-word-fall-through FIFO for the DSP core.
module tt_dsp_sample_framer #(
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [7:0]               in_byte,
  input  logic                     in_strobe,
  output logic [15:0]              out_sample,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic {
    StFirst,
    StSecond
  } phase_e;

  logic            sync_s1_q, sync_s2_q, sync_s3_q;
  phase_e          phase_q, phase_d;
  logic [7:0]      hold_q;
  logic [15:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q, level_d;
  logic            overflow_q;

  logic            byte_evt;
  logic            push, pop, full, push_ok;
  logic [15:0]     sample_new;

  // Rising edge of the synchronized strobe; gated by ena so disabled bytes never reach the pairer.
  assign byte_evt   = sync_s2_q & ~sync_s3_q & ena;
  assign push       = byte_evt & (phase_q == StSecond);
  assign pop        = out_valid & out_ready;
  assign full       = (level_q == LvlW'(DEPTH));
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok    = push & (~full | pop);
  assign sample_new = MSB_FIRST ? {hold_q, in_byte} : {in_byte, hold_q};

  assign out_sample = mem_q[rd_ptr_q];
  assign out_valid  = (level_q != '0);
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1_q <= 1'b0;
      sync_s2_q <= 1'b0;
      sync_s3_q <= 1'b0;
    end else begin
      sync_s1_q <= in_strobe;
      sync_s2_q <= sync_s1_q;
      sync_s3_q <= sync_s2_q;
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (!ena) begin
      phase_d = StFirst;
    end else if (byte_evt) begin
      unique case (phase_q)
        StFirst:  phase_d = StSecond;
        StSecond: phase_d = StFirst;
        default:  phase_d = StFirst;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= StFirst;
      hold_q  <= 8'h00;
    end else begin
      phase_q <= phase_d;
      if (byte_evt && (phase_q == StFirst)) begin
        hold_q <= in_byte;
      end
    end
  end

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (!push_ok && pop) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 16'h0000;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= sample_new;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      level_q <= level_d;
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tt_dsp_sample_framer.sv
// Bench for tt_dsp_sample_framer: one instance per byte order, driven in lockstep,
// with a byte-pair vector table and per-instance expected-sample queues.
module tb_tt_dsp_sample_framer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_strobe = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] smp0, smp1;
  logic        vld0, vld1, ovf0, ovf1;
  logic [2:0]  lvl0, lvl1;

  always #5 clk = ~clk;

  tt_dsp_sample_framer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_byte(in_byte), .in_strobe(in_strobe),
    .out_sample(smp0), .out_valid(vld0), .out_ready(out_ready), .overflow(ovf0),
    .fifo_level(lvl0)
  );

  tt_dsp_sample_framer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_byte(in_byte), .in_strobe(in_strobe),
    .out_sample(smp1), .out_valid(vld1), .out_ready(out_ready), .overflow(ovf1),
    .fifo_level(lvl1)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] e_lo;
    logic [15:0] e_hi;
  } vec_t;

  vec_t        vecs [10];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  int          total = 0;
  int          bad = 0;
  int          mlevel = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_strobe = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_valid0", 32'(vld0), 32'd0);
    check("rst_valid1", 32'(vld1), 32'd0);
    check("rst_level0", 32'(lvl0), 32'd0);
    check("rst_ovf0", 32'(ovf0), 32'd0);
    check("rst_ovf1", 32'(ovf1), 32'd0);
    check("rst_sample0", 32'(smp0), 32'd0);
    check("rst_sample1", 32'(smp1), 32'd0);
    q0.delete();
    q1.delete();
    mlevel = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: plain; mode 1: check push latency on an empty FIFO; mode 2: pop on the push edge.
  task automatic send_byte(input logic [7:0] b, input int mode);
    @(negedge clk);
    in_byte = b;
    in_strobe = 1'b1;
    @(posedge clk); #1;
    if (mode == 1) check("lat_k0_valid", 32'(vld0), 32'd0);
    @(posedge clk); #1;
    if (mode == 1) check("lat_k1_valid", 32'(vld0), 32'd0);
    if (mode == 2) begin
      @(negedge clk);
      check("pushpop_head0", 32'(smp0), 32'(q0.pop_front()));
      check("pushpop_head1", 32'(smp1), 32'(q1.pop_front()));
      mlevel--;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    if (mode == 1) begin
      check("lat_k2_valid0", 32'(vld0), 32'd1);
      check("lat_k2_valid1", 32'(vld1), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_strobe = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_vec(input int idx, input int mode);
    send_byte(vecs[idx].b0, 0);
    send_byte(vecs[idx].b1, mode);
    if (mlevel < int'(DEPTH)) begin
      q0.push_back(vecs[idx].e_lo);
      q1.push_back(vecs[idx].e_hi);
      mlevel++;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("drain_valid0", 32'(vld0), 32'd1);
      check("drain_valid1", 32'(vld1), 32'd1);
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL drain_sb: got sample %0h want none (scoreboard empty)", smp0);
      end else begin
        check("drain_sample0", 32'(smp0), 32'(q0.pop_front()));
        check("drain_sample1", 32'(smp1), 32'(q1.pop_front()));
        mlevel--;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_level0", 32'(lvl0), 32'(mlevel));
    check("drain_after_valid0", 32'(vld0), 32'(mlevel != 0));
  endtask

  initial begin
    vecs[0] = '{b0: 8'h34, b1: 8'h12, e_lo: 16'h1234, e_hi: 16'h3412};
    vecs[1] = '{b0: 8'hAB, b1: 8'hCD, e_lo: 16'hCDAB, e_hi: 16'hABCD};
    vecs[2] = '{b0: 8'h01, b1: 8'h02, e_lo: 16'h0201, e_hi: 16'h0102};
    vecs[3] = '{b0: 8'h10, b1: 8'h20, e_lo: 16'h2010, e_hi: 16'h1020};
    vecs[4] = '{b0: 8'h31, b1: 8'h42, e_lo: 16'h4231, e_hi: 16'h3142};
    vecs[5] = '{b0: 8'h53, b1: 8'h64, e_lo: 16'h6453, e_hi: 16'h5364};
    vecs[6] = '{b0: 8'h75, b1: 8'h86, e_lo: 16'h8675, e_hi: 16'h7586};
    vecs[7] = '{b0: 8'h97, b1: 8'hA8, e_lo: 16'hA897, e_hi: 16'h97A8};
    vecs[8] = '{b0: 8'h11, b1: 8'h22, e_lo: 16'h2211, e_hi: 16'h1122};
    vecs[9] = '{b0: 8'h78, b1: 8'h56, e_lo: 16'h5678, e_hi: 16'h7856};

    do_reset();

    // Single pair with exact push latency.
    send_vec(0, 1);
    check("pair1_level0", 32'(lvl0), 32'd1);
    drain(1);

    // Two pairs, order preserved in both byte orders.
    send_vec(1, 0);
    send_vec(2, 0);
    check("two_level0", 32'(lvl0), 32'd2);
    check("two_level1", 32'(lvl1), 32'd2);
    drain(2);

    // Five pairs into a depth-4 FIFO: last one dropped, overflow sticky.
    for (int i = 3; i <= 7; i++) send_vec(i, 0);
    check("ovf_level0", 32'(lvl0), 32'd4);
    check("ovf_flag0", 32'(ovf0), 32'd1);
    check("ovf_flag1", 32'(ovf1), 32'd1);
    drain(4);
    check("ovf_sticky0", 32'(ovf0), 32'd1);

    // Full FIFO with a pop on the completing push edge.
    do_reset();
    for (int i = 3; i <= 6; i++) send_vec(i, 0);
    check("full_level0", 32'(lvl0), 32'd4);
    send_vec(7, 2);
    check("pushpop_level0", 32'(lvl0), 32'd4);
    check("pushpop_ovf0", 32'(ovf0), 32'd0);
    drain(4);

    // Reset between the two bytes of a pair discards the first byte.
    send_byte(8'h55, 0);
    do_reset();
    send_vec(8, 0);
    check("midrst_level0", 32'(lvl0), 32'd1);
    check("midrst_ovf0", 32'(ovf0), 32'd0);
    drain(1);

    // ena low ignores the byte and returns the pairer to the first byte.
    send_byte(8'hEE, 0);
    @(negedge clk);
    ena = 1'b0;
    send_byte(8'h99, 0);
    @(negedge clk);
    ena = 1'b1;
    send_vec(9, 0);
    check("ena_level0", 32'(lvl0), 32'd1);
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
